// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus responder.
// Holds the FSM encoding, word/counter widths and the byte-address limit helper.
package mem_bus_pkg;

    localparam int WORD_W     = 32;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // First byte address beyond a RAM of the given depth in 32-bit words.
    function automatic logic [32:0] byte_limit(input int unsigned depth);
        logic [32:0] lim;
        lim = {1'b0, depth[31:0]} << 2;
        return lim;
    endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port DEPTH x 32 RAM, one-cycle registered read, write on enable; no reset.
// Read data holds until the next enabled read.
module mem_bus_ram
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory responder: accepts one request when idle, response pulse 2+WAIT_STATES cycles later.
// Requests while busy are dropped; MEM_BUS_RESPONDER_CHECK_EN adds alignment/range error checks.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_e                state_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [AW-1:0]         widx_q;
    logic [WORD_W-1:0]     wdata_q;
    logic                  is_rd_q;
    logic                  acc_err_q;
    logic                  resp_valid_q;
    logic                  rdata_sel_q;

    logic                  accept_d;
    logic                  addr_err_d;
    logic                  ram_we;
    logic                  ram_re;
    logic [WORD_W-1:0]     ram_rdata;

    assign ready    = (state_q == IDLE) && !rst;
    assign accept_d = ready && (req_read || req_write);

`ifdef MEM_BUS_RESPONDER_CHECK_EN
    assign addr_err_d = (addr[1:0] != 2'b00) || ({1'b0, addr} >= byte_limit(DEPTH));
    assign err        = resp_valid_q && acc_err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
    assign addr_err_d       = 1'b0;
    assign err              = 1'b0;
`endif

    // Reset arriving at the ACCESS exit edge must suppress the RAM operation.
    assign ram_we = (state_q == ACCESS) && !rst && !is_rd_q && !acc_err_q;
    assign ram_re = (state_q == ACCESS) && !rst &&  is_rd_q && !acc_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            widx_q       <= '0;
            wdata_q      <= '0;
            is_rd_q      <= 1'b0;
            acc_err_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_sel_q  <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        widx_q    <= addr[AW+1:2];
                        wdata_q   <= wdata;
                        is_rd_q   <= req_read;
                        acc_err_q <= addr_err_d;
                        if (WAIT_STATES > 0) begin
                            state_q    <= WAIT;
                            wait_cnt_q <= WAIT_LOAD;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= ACCESS;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                ACCESS: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    // Erroring reads present zero; rdata otherwise tracks the RAM read register.
                    if (is_rd_q) begin
                        rdata_sel_q <= !acc_err_q;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_sel_q ? ram_rdata : '0;

    mem_bus_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (widx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) driven with directed requests.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic [1:0]  req_read = 2'b00;
    logic [1:0]  req_write = 2'b00;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [1:0]  ready;
    logic [1:0]  resp_valid;
    logic [31:0] rdata [2];
    logic [1:0]  err;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int          unit;
        int          cyc;
        logic [31:0] rdata;
        bit          err;
        bit          is_rd;
    } exp_t;

    exp_t exp_q[$];

`ifdef MEM_BUS_RESPONDER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_read(req_read[0]), .req_write(req_write[0]),
        .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]),
        .resp_valid(resp_valid[0]), .rdata(rdata[0]), .err(err[0])
    );

    mem_bus_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst[1]), .req_read(req_read[1]), .req_write(req_write[1]),
        .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]),
        .resp_valid(resp_valid[1]), .rdata(rdata[1]), .err(err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input int u, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input bit exp_err, input bit spam);
        int guard = 0;
        int busy = 0;
        int w = (u == 1) ? 3 : 0;
        while (!ready[u] && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!ready[u]) begin
            chk("ready_before_issue", 32'(ready[u]), 32'd1);
            return;
        end
        req_read[u]  = rd;
        req_write[u] = wr;
        addr[u]      = a;
        wdata[u]     = d;
        exp_q.push_back('{u, cyc + 2 + w, exp_rd, exp_err, rd});
        @(negedge clk);
        req_read[u]  = 1'b0;
        req_write[u] = 1'b0;
        while (!ready[u] && busy < 40) begin
            busy++;
            if (spam) req_read[u] = busy[0];
            @(negedge clk);
        end
        req_read[u] = 1'b0;
        chk("busy_cycles", 32'(busy), 32'(2 + w));
    endtask

    initial begin
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        fork
            forever begin
                @(negedge clk);
                for (int u = 0; u < 2; u++) begin
                    if (resp_valid[u]) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_resp", 32'(u), 32'hFFFF_FFFF);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("resp_unit", 32'(u), 32'(e.unit));
                            chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                            chk("resp_err", 32'(err[u]), 32'(e.err));
                            if (e.is_rd) chk("resp_rdata", rdata[u], e.rdata);
                        end
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values on both units
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", 32'(ready[u]), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid[u]), 32'd0);
            chk("rst_rdata", rdata[u], 32'd0);
            chk("rst_err", 32'(err[u]), 32'd0);
        end
        rst = 2'b00;
        @(negedge clk);
        chk("ready_after_rst0", 32'(ready[0]), 32'd1);
        chk("ready_after_rst1", 32'(ready[1]), 32'd1);

        // Zero wait states: write then read back
        issue(0, 0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        issue(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

        // Three wait states, with ignored read pulses while busy
        issue(1, 0, 1, 32'h10, 32'h0BADF00D, 32'h0, 0, 0);
        issue(1, 1, 0, 32'h10, 32'h0, 32'h0BADF00D, 0, 1);

        // Simultaneous read and write: read wins, memory untouched
        issue(1, 0, 1, 32'h20, 32'hA5A5A5A5, 32'h0, 0, 0);
        issue(1, 1, 1, 32'h20, 32'h12345678, 32'hA5A5A5A5, 0, 0);
        issue(1, 1, 0, 32'h20, 32'h0, 32'hA5A5A5A5, 0, 0);

        // Reset during WAIT of a write aborts it with no response
        issue(1, 0, 1, 32'h30, 32'h0, 32'h0, 0, 0);
        req_write[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        req_write[1] = 1'b0;
        rst[1] = 1'b1;
        @(negedge clk);
        chk("ready_in_rst_a", 32'(ready[1]), 32'd0);
        @(negedge clk);
        chk("ready_in_rst_b", 32'(ready[1]), 32'd0);
        rst[1] = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 32'(ready[1]), 32'd1);
        chk("rdata_after_midrst", rdata[1], 32'd0);
        issue(1, 1, 0, 32'h30, 32'h0, 32'h0, 0, 0);

        // Misaligned and out-of-range addresses
        issue(0, 0, 1, 32'h08, 32'h22222222, 32'h0, 0, 0);
        issue(0, 1, 0, 32'h12, 32'h0, CHK ? 32'h0 : 32'hDEADBEEF, CHK, 0);
        issue(0, 0, 1, 32'h1008, 32'h99999999, 32'h0, CHK, 0);
        issue(0, 1, 0, 32'h08, 32'h0, CHK ? 32'h22222222 : 32'h99999999, 0, 0);
        issue(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

        repeat (8) @(negedge clk);
        chk("pending_responses", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
